// File: rtl/game_flow_ctrl.sv
// Sokoban game-flow FSM: sequences init/move/retract/stage advance with a move counter and undo budget.
// Define STEP_LIMIT_EN to add the FAIL state entered once move_count reaches MAX_MOVES on an unsolved board.
module game_flow_ctrl #(
  parameter int unsigned CELLS      = 64,
  parameter int unsigned STAGE_W    = 2,
  parameter int unsigned LAST_STAGE = 2,
  parameter int unsigned UNDO_DEPTH = 4,
  parameter int unsigned MOVE_W     = 10,
  parameter int unsigned MAX_MOVES  = 500
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               restart,
  input  logic               click,
  input  logic               retry,
  input  logic               retract,
  input  logic               game_area,
  input  logic               move_result,
  input  logic [CELLS-1:0]   box_map,
  input  logic [CELLS-1:0]   destination,
  input  logic [STAGE_W-1:0] stage,
  output logic               state_en,
  output logic [1:0]         sel,
  output logic               stage_up,
  output logic               win,
  output logic               fail,
  output logic [MOVE_W-1:0]  move_count,
  output logic               undo_avail
);

  localparam int unsigned UNDO_W = $clog2(UNDO_DEPTH + 1);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_INIT    = 4'd1,
    S_WAIT    = 4'd2,
    S_INTERIM = 4'd3,
    S_MOVE    = 4'd4,
    S_RETRACT = 4'd5,
    S_PAUSE   = 4'd6,
    S_NEXT    = 4'd7,
`ifdef STEP_LIMIT_EN
    S_FAIL    = 4'd9,
`endif
    S_OVER    = 4'd8
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [MOVE_W-1:0]   r_move_count;
  logic [UNDO_W-1:0]   r_undo_cnt;
  logic                w_solved;

  assign w_solved = (box_map == destination);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_RESET;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_INIT;
      S_INIT:  w_next = S_WAIT;
      S_WAIT: begin
        // A solved board takes precedence over any click in the same cycle.
        if (w_solved)
          w_next = (stage == STAGE_W'(LAST_STAGE)) ? S_OVER : S_PAUSE;
`ifdef STEP_LIMIT_EN
        else if (r_move_count == MOVE_W'(MAX_MOVES))
          w_next = S_FAIL;
`endif
        else if (click)
          w_next = S_INTERIM;
      end
      S_INTERIM: begin
        if (retry)                       w_next = S_INIT;
        else if (retract)                w_next = (r_undo_cnt != '0) ? S_RETRACT : S_WAIT;
        else if (game_area && move_result) w_next = S_MOVE;
        else                             w_next = S_WAIT;
      end
      S_MOVE:    w_next = S_WAIT;
      S_RETRACT: w_next = S_WAIT;
      S_PAUSE:   if (click) w_next = S_NEXT;
      S_NEXT:    w_next = S_INIT;
      S_OVER:    w_next = S_OVER;
`ifdef STEP_LIMIT_EN
      S_FAIL:    if (click) w_next = S_INIT;
`endif
      default:   w_next = S_RESET;
    endcase
    if (restart) w_next = S_RESET;
  end

  // Counters clear on entry to RESET/INIT so INIT already presents a zero count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_move_count <= '0;
      r_undo_cnt   <= '0;
    end else if (w_next == S_RESET || w_next == S_INIT) begin
      r_move_count <= '0;
      r_undo_cnt   <= '0;
    end else if (r_state == S_MOVE) begin
      if (r_move_count != '1)                 r_move_count <= r_move_count + 1'b1;
      if (r_undo_cnt != UNDO_W'(UNDO_DEPTH))  r_undo_cnt   <= r_undo_cnt + 1'b1;
    end else if (r_state == S_RETRACT) begin
      if (r_move_count != '0) r_move_count <= r_move_count - 1'b1;
      if (r_undo_cnt != '0)   r_undo_cnt   <= r_undo_cnt - 1'b1;
    end
  end

  always_comb begin
    state_en = 1'b0;
    sel      = 2'd0;
    stage_up = 1'b0;
    win      = 1'b0;
    fail     = 1'b0;
    case (r_state)
      S_RESET, S_INIT: state_en = 1'b1;
      S_MOVE: begin
        state_en = 1'b1;
        sel      = 2'd1;
      end
      S_RETRACT: begin
        state_en = 1'b1;
        sel      = 2'd3;
      end
      S_NEXT: stage_up = 1'b1;
      S_OVER: win      = 1'b1;
`ifdef STEP_LIMIT_EN
      S_FAIL: fail     = 1'b1;
`endif
      default: ;
    endcase
  end

  assign move_count = r_move_count;
  assign undo_avail = (r_undo_cnt != '0);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl (UNDO_DEPTH=2, MAX_MOVES=3, 8-cell map).
module tb_game_flow_ctrl;

  logic       clk;
  logic       reset_n;
  logic       restart;
  logic       click;
  logic       retry;
  logic       retract;
  logic       game_area;
  logic       move_result;
  logic [7:0] box_map;
  logic [7:0] destination;
  logic [1:0] stage;
  logic       state_en;
  logic [1:0] sel;
  logic       stage_up;
  logic       win;
  logic       fail;
  logic [9:0] move_count;
  logic       undo_avail;

  int checks = 0;
  int errors = 0;

  game_flow_ctrl #(
    .CELLS(8), .STAGE_W(2), .LAST_STAGE(2), .UNDO_DEPTH(2), .MOVE_W(10), .MAX_MOVES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart), .click(click), .retry(retry),
    .retract(retract), .game_area(game_area), .move_result(move_result),
    .box_map(box_map), .destination(destination), .stage(stage),
    .state_en(state_en), .sel(sel), .stage_up(stage_up), .win(win), .fail(fail),
    .move_count(move_count), .undo_avail(undo_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_move(input int k);
    click = 1'b1;
    tick();
    click = 1'b0;
    chk("mv_interim_en", 32'(state_en), 32'd0);
    tick();
    chk("mv_sel", 32'(sel), 32'd1);
    chk("mv_en", 32'(state_en), 32'd1);
    tick();
    chk("mv_wait_sel", 32'(sel), 32'd0);
    chk("mv_count", 32'(move_count), 32'(k));
  endtask

  task automatic do_retract(input int cnt, input logic undo);
    click = 1'b1;
    tick();
    click = 1'b0;
    tick();
    chk("rt_sel", 32'(sel), 32'd3);
    chk("rt_en", 32'(state_en), 32'd1);
    tick();
    chk("rt_count", 32'(move_count), 32'(cnt));
    chk("rt_undo", 32'(undo_avail), 32'(undo));
  endtask

  initial begin
    reset_n = 1'b0; restart = 1'b0; click = 1'b0; retry = 1'b0; retract = 1'b0;
    game_area = 1'b0; move_result = 1'b0;
    box_map = 8'h0F; destination = 8'hF0; stage = 2'd0;
    #1;
    chk("rst_en", 32'(state_en), 32'd1);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_stage_up", 32'(stage_up), 32'd0);
    chk("rst_win", 32'(win), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_count", 32'(move_count), 32'd0);
    chk("rst_undo", 32'(undo_avail), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_reset_en", 32'(state_en), 32'd1);
    tick();
    chk("rel_init_en", 32'(state_en), 32'd1);
    tick();
    chk("rel_wait_en", 32'(state_en), 32'd0);

    game_area = 1'b1;
    move_result = 1'b1;
`ifdef STEP_LIMIT_EN
    for (int k = 1; k <= 3; k++) do_move(k);
    tick();
    chk("lim_fail", 32'(fail), 32'd1);
    chk("lim_en", 32'(state_en), 32'd0);
    click = 1'b1;
    tick();
    click = 1'b0;
    chk("lim_clr_fail", 32'(fail), 32'd0);
    chk("lim_init_en", 32'(state_en), 32'd1);
    chk("lim_count", 32'(move_count), 32'd0);
    tick();
    chk("lim_wait_en", 32'(state_en), 32'd0);
`else
    for (int k = 1; k <= 3; k++) do_move(k);
    chk("mv3_undo", 32'(undo_avail), 32'd1);
    chk("mv3_fail", 32'(fail), 32'd0);
    retract = 1'b1;
    game_area = 1'b0;
    do_retract(2, 1'b1);
    do_retract(1, 1'b0);
    click = 1'b1;
    tick();
    click = 1'b0;
    tick();
    chk("rt3_sel", 32'(sel), 32'd0);
    chk("rt3_en", 32'(state_en), 32'd0);
    chk("rt3_count", 32'(move_count), 32'd1);
    retract = 1'b0;
    game_area = 1'b1;
`endif

    // Asynchronous reset in the middle of a MOVE cycle.
    click = 1'b1;
    tick();
    click = 1'b0;
    tick();
    chk("ar_move_sel", 32'(sel), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_en", 32'(state_en), 32'd1);
    chk("ar_sel", 32'(sel), 32'd0);
    chk("ar_count", 32'(move_count), 32'd0);
    chk("ar_undo", 32'(undo_avail), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ar_rel_reset_en", 32'(state_en), 32'd1);
    tick();
    chk("ar_rel_init_en", 32'(state_en), 32'd1);
    tick();
    chk("ar_rel_wait_en", 32'(state_en), 32'd0);

    // Retry wins over retract and game_area.
    do_move(1);
    retry = 1'b1;
    retract = 1'b1;
    click = 1'b1;
    tick();
    click = 1'b0;
    tick();
    chk("retry_init_en", 32'(state_en), 32'd1);
    chk("retry_sel", 32'(sel), 32'd0);
    chk("retry_count", 32'(move_count), 32'd0);
    chk("retry_undo", 32'(undo_avail), 32'd0);
    retry = 1'b0;
    retract = 1'b0;
    tick();

    // Solve beats click, then stage advance and final win.
    box_map = 8'hF0;
    stage = 2'd1;
    click = 1'b1;
    tick();
    click = 1'b0;
    chk("pause_en", 32'(state_en), 32'd0);
    chk("pause_sel", 32'(sel), 32'd0);
    chk("pause_win", 32'(win), 32'd0);
    tick();
    chk("pause_hold_up", 32'(stage_up), 32'd0);
    click = 1'b1;
    tick();
    click = 1'b0;
    chk("next_up", 32'(stage_up), 32'd1);
    chk("next_en", 32'(state_en), 32'd0);
    stage = 2'd2;
    tick();
    chk("next_up_once", 32'(stage_up), 32'd0);
    chk("next_init_en", 32'(state_en), 32'd1);
    tick();
    chk("last_wait_win", 32'(win), 32'd0);
    tick();
    chk("over_win", 32'(win), 32'd1);
    for (int i = 0; i < 3; i++) begin
      click = 1'b1;
      tick();
      click = 1'b0;
      chk("over_hold_win", 32'(win), 32'd1);
      chk("over_en", 32'(state_en), 32'd0);
    end
    restart = 1'b1;
    tick();
    chk("restart_win", 32'(win), 32'd0);
    chk("restart_en", 32'(state_en), 32'd1);
    chk("restart_count", 32'(move_count), 32'd0);
    restart = 1'b0;
    tick();
    chk("restart_init_en", 32'(state_en), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
